// File: rtl/mtr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mtr_pkg                                                       |
// | Brief    : Shared duty type, channel state encoding and duty clamping.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package mtr_pkg;

  typedef logic signed [11:0] duty_t;

  localparam duty_t DUTY_MAX = 12'sd2047;
  localparam duty_t DUTY_MIN = -12'sd2047;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DEAD = 2'd2
  } chan_state_t;

  // Folds a 13-bit intermediate back into the symmetric duty range.
  function automatic duty_t clamp_duty(input logic signed [12:0] v);
    if (v > 13'sd2047) begin
      return DUTY_MAX;
    end else if (v < -13'sd2047) begin
      return DUTY_MIN;
    end
    return v[11:0];
  endfunction

  function automatic duty_t sat_duty(input duty_t v);
    return clamp_duty({v[11], v});
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_ramp_ctrl_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ramp_chan                                                     |
// | Brief    : One duty channel: slew toward target, dead time on reversal.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ramp_chan
  import mtr_pkg::*;
#(
  parameter int DEAD_CYC = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic signed [11:0] i_tgt,
  input  logic [11:0]        i_step,
  input  logic               i_abort,
  output logic signed [11:0] o_cur,
  output logic [1:0]         o_state
);

  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;

  chan_state_t        r_state;
  chan_state_t        w_state_nxt;
  chan_state_t        w_step_state;
  logic signed [11:0] r_cur;
  logic signed [11:0] w_cur_nxt;
  logic [DW-1:0]      r_dead;
  logic [DW-1:0]      w_dead_nxt;
  logic signed [12:0] w_c;
  logic signed [12:0] w_t;
  logic signed [12:0] w_s;
  logic signed [12:0] w_diff;
  logic signed [12:0] w_abs_c;
  logic signed [12:0] w_abs_d;
  logic signed [12:0] w_stepped;
  logic               w_oppose;
  logic               w_zero_hit;
  logic               w_reach;
  logic               w_do_step;

  assign w_c      = {r_cur[11], r_cur};
  assign w_t      = {i_tgt[11], i_tgt};
  assign w_s      = {1'b0, i_step};
  assign w_diff   = w_t - w_c;
  assign w_abs_c  = w_c[12] ? -w_c : w_c;
  assign w_abs_d  = w_diff[12] ? -w_diff : w_diff;

  // A reversal must first bring the channel to zero and sit out the dead time.
  assign w_oppose   = (r_cur != 12'sd0) && (i_tgt != 12'sd0) && (r_cur[11] != i_tgt[11]);
  assign w_zero_hit = w_oppose && (w_abs_c <= w_s);
  assign w_reach    = !w_oppose && (w_abs_d <= w_s);
  assign w_do_step  = i_tick && (((r_state == IDLE) && (i_tgt != r_cur)) || (r_state == RAMP));

  always_comb begin
    w_stepped = w_c;
    if (w_oppose) begin
      if (w_zero_hit) begin
        w_stepped = '0;
      end else if (w_c[12]) begin
        w_stepped = w_c + w_s;
      end else begin
        w_stepped = w_c - w_s;
      end
    end else if (w_reach) begin
      w_stepped = w_t;
    end else if (w_diff[12]) begin
      w_stepped = w_c - w_s;
    end else begin
      w_stepped = w_c + w_s;
    end
    w_step_state = w_zero_hit ? DEAD : (w_reach ? IDLE : RAMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_dead  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_dead  <= w_dead_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_tgt != r_cur) begin
          w_state_nxt = i_tick ? w_step_state : RAMP;
        end
      end
      RAMP: begin
        if (i_tick) begin
          w_state_nxt = w_step_state;
        end else if (i_tgt == r_cur) begin
          w_state_nxt = IDLE;
        end
      end
      DEAD: begin
        if (i_abort || (i_tgt == 12'sd0)) begin
          w_state_nxt = IDLE;
        end else if (r_dead <= DW'(1)) begin
          w_state_nxt = RAMP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cur_nxt  = r_cur;
    w_dead_nxt = r_dead;
    if (w_do_step) begin
      w_cur_nxt = clamp_duty(w_stepped);
      if (w_zero_hit) begin
        w_dead_nxt = DW'(DEAD_CYC);
      end
    end else if ((r_state == DEAD) && (r_dead != '0)) begin
      w_dead_nxt = r_dead - 1'b1;
    end
  end

  assign o_cur   = r_cur;
  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/mtr_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mtr_ramp_ctrl                                                 |
// | Brief    : Motor duty sequencer: command handshake, ramp tick, e-stop.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mtr_ramp_ctrl
  import mtr_pkg::*;
#(
  parameter int TICK_CYC   = 1024,
  parameter int STEP       = 8,
  parameter int ESTOP_STEP = 32,
  parameter int DEAD_CYC   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cmd_vld,
  input  logic signed [11:0] i_cmd_lft,
  input  logic signed [11:0] i_cmd_rght,
  output logic               o_cmd_rdy,
  input  logic               i_estop,
  output logic signed [11:0] o_lft_duty,
  output logic signed [11:0] o_rght_duty,
  output logic               o_busy,
  output logic               o_stopped
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          w_accept;
  logic          w_both_zero;
  logic          r_estop_lat;
  logic          r_busy;
  duty_t         r_tgt_lft;
  duty_t         r_tgt_rght;
  duty_t         w_tgt_lft;
  duty_t         w_tgt_rght;
  logic [11:0]   w_step;
  logic [1:0]    w_state_lft;
  logic [1:0]    w_state_rght;

  assign w_tick      = (r_tick_cnt == TW'(TICK_CYC - 1));
  assign o_cmd_rdy   = !i_estop && !r_estop_lat;
  assign w_accept    = i_cmd_vld && o_cmd_rdy;
  assign w_both_zero = (o_lft_duty == '0) && (o_rght_duty == '0);

  // While stopping, both channels chase zero at the faster rate.
  assign w_tgt_lft  = r_estop_lat ? '0 : r_tgt_lft;
  assign w_tgt_rght = r_estop_lat ? '0 : r_tgt_rght;
  assign w_step     = r_estop_lat ? 12'(ESTOP_STEP) : 12'(STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Clearing the stored targets on e-stop keeps an old command from resuming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt_lft   <= '0;
      r_tgt_rght  <= '0;
      r_estop_lat <= 1'b0;
    end else begin
      if (i_estop) begin
        r_tgt_lft  <= '0;
        r_tgt_rght <= '0;
      end else if (w_accept) begin
        r_tgt_lft  <= sat_duty(i_cmd_lft);
        r_tgt_rght <= sat_duty(i_cmd_rght);
      end
      if (i_estop) begin
        r_estop_lat <= 1'b1;
      end else if (w_both_zero) begin
        r_estop_lat <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_lft != IDLE) || (w_state_rght != IDLE);
    end
  end

  ramp_chan #(
    .DEAD_CYC (DEAD_CYC)
  ) u_lft (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (w_tick),
    .i_tgt   (w_tgt_lft),
    .i_step  (w_step),
    .i_abort (r_estop_lat),
    .o_cur   (o_lft_duty),
    .o_state (w_state_lft)
  );

  ramp_chan #(
    .DEAD_CYC (DEAD_CYC)
  ) u_rght (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (w_tick),
    .i_tgt   (w_tgt_rght),
    .i_step  (w_step),
    .i_abort (r_estop_lat),
    .o_cur   (o_rght_duty),
    .o_state (w_state_rght)
  );

  assign o_busy    = r_busy;
  assign o_stopped = r_estop_lat && w_both_zero;

endmodule
`default_nettype wire

// File: tb/tb_mtr_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mtr_ramp_ctrl                                              |
// | Brief    : Directed bench with a per-cycle reference model of the ramps. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mtr_ramp_ctrl;

  localparam int TICK_CYC   = 4;
  localparam int STEP       = 8;
  localparam int ESTOP_STEP = 32;
  localparam int DEAD_CYC   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_cmd_vld = 1'b0;
  logic signed [11:0] i_cmd_lft = '0;
  logic signed [11:0] i_cmd_rght = '0;
  logic               i_estop = 1'b0;
  logic               o_cmd_rdy;
  logic signed [11:0] o_lft_duty;
  logic signed [11:0] o_rght_duty;
  logic               o_busy;
  logic               o_stopped;

  int total = 0;
  int bad   = 0;

  mtr_ramp_ctrl #(
    .TICK_CYC   (TICK_CYC),
    .STEP       (STEP),
    .ESTOP_STEP (ESTOP_STEP),
    .DEAD_CYC   (DEAD_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_vld   (i_cmd_vld),
    .i_cmd_lft   (i_cmd_lft),
    .i_cmd_rght  (i_cmd_rght),
    .o_cmd_rdy   (o_cmd_rdy),
    .i_estop     (i_estop),
    .o_lft_duty  (o_lft_duty),
    .o_rght_duty (o_rght_duty),
    .o_busy      (o_busy),
    .o_stopped   (o_stopped)
  );

  always #5 clk = ~clk;

  // Reference model: applied duty, stored target, remaining dead cycles,
  // and whether each channel still has work to do.
  int m_cnt;
  bit m_lat;
  bit m_busy;
  int m_tgt [2];
  int m_cur [2];
  int m_dead[2];
  bit m_act [2];
  int n_cnt;
  bit n_lat;
  bit n_busy;
  int n_tgt [2];
  int n_cur [2];
  int n_dead[2];
  bit n_act [2];
  bit tk;
  bit z;
  int eff;
  int s;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat(input int v);
    return (v < -2047) ? -2047 : v;
  endfunction

  function automatic int toward(input int c, input int t, input int st, output bit zd);
    zd = 1'b0;
    if (c != 0 && t != 0 && ((c > 0) != (t > 0))) begin
      if (iabs(c) <= st) begin
        zd = 1'b1;
        return 0;
      end
      return (c > 0) ? c - st : c + st;
    end
    if (iabs(t - c) <= st) return t;
    return (t > c) ? c + st : c - st;
  endfunction

  always_comb begin
    tk     = (m_cnt == TICK_CYC - 1);
    z      = 1'b0;
    eff    = 0;
    s      = 0;
    n_cnt  = (m_cnt + 1) % TICK_CYC;
    n_busy = m_act[0] || m_act[1];
    n_lat  = i_estop ? 1'b1 : ((m_cur[0] == 0 && m_cur[1] == 0) ? 1'b0 : m_lat);
    for (int c = 0; c < 2; c++) begin
      n_cur[c]  = m_cur[c];
      n_dead[c] = 0;
      n_act[c]  = 1'b0;
      n_tgt[c]  = m_tgt[c];
      eff = m_lat ? 0 : m_tgt[c];
      s   = m_lat ? ESTOP_STEP : STEP;
      if (m_dead[c] > 0) begin
        n_cur[c] = 0;
        if (eff != 0) begin
          n_dead[c] = m_dead[c] - 1;
          n_act[c]  = 1'b1;
        end
      end else if (tk && m_cur[c] != eff) begin
        n_cur[c]  = toward(m_cur[c], eff, s, z);
        n_dead[c] = z ? DEAD_CYC : 0;
        n_act[c]  = z || (n_cur[c] != eff);
      end else begin
        n_act[c] = (m_cur[c] != eff);
      end
    end
    if (i_estop) begin
      n_tgt[0] = 0;
      n_tgt[1] = 0;
    end else if (i_cmd_vld && !m_lat) begin
      n_tgt[0] = sat(int'(i_cmd_lft));
      n_tgt[1] = sat(int'(i_cmd_rght));
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_lat  <= 1'b0;
      m_busy <= 1'b0;
      m_tgt  <= '{0, 0};
      m_cur  <= '{0, 0};
      m_dead <= '{0, 0};
      m_act  <= '{1'b0, 1'b0};
    end else begin
      m_cnt  <= n_cnt;
      m_lat  <= n_lat;
      m_busy <= n_busy;
      m_tgt  <= n_tgt;
      m_cur  <= n_cur;
      m_dead <= n_dead;
      m_act  <= n_act;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired, got no event, expected event (t=%0t)", nm, $time);
  endtask

  always @(negedge clk) begin
    chk("lft_vs_model", int'(o_lft_duty), m_cur[0]);
    chk("rght_vs_model", int'(o_rght_duty), m_cur[1]);
    chk("busy_vs_model", int'(o_busy), int'(m_busy));
    chk("stopped_vs_model", int'(o_stopped), int'(m_lat && m_cur[0] == 0 && m_cur[1] == 0));
    chk("rdy_vs_model", int'(o_cmd_rdy), int'(!i_estop && !m_lat));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int l, input int r);
    i_cmd_vld  = 1'b1;
    i_cmd_lft  = 12'(l);
    i_cmd_rght = 12'(r);
    cyc(1);
    i_cmd_vld  = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (m_cnt != 0 && n <= TICK_CYC);
    if (m_cnt != 0) bound_fail("wait_tick");
  endtask

  function automatic bit settled();
    for (int c = 0; c < 2; c++) begin
      if (m_cur[c] != (m_lat ? 0 : m_tgt[c]) || m_dead[c] != 0 || m_act[c]) return 1'b0;
    end
    return !m_busy;
  endfunction

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (!settled() && n < lim) begin
      cyc(1);
      n++;
    end
    if (!settled()) bound_fail("wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    cyc(3);
    chk("reset_lft", int'(o_lft_duty), 0);
    chk("reset_rght", int'(o_rght_duty), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_stopped", int'(o_stopped), 0);
    chk("reset_rdy", int'(o_cmd_rdy), 1);
    rst = 1'b0;
    cyc(2);

    // Basic ramp in both directions.
    send(20, -16);
    wait_tick();
    chk("ramp_l1", int'(o_lft_duty), 8);
    chk("ramp_r1", int'(o_rght_duty), -8);
    wait_tick();
    chk("ramp_l2", int'(o_lft_duty), 16);
    chk("ramp_r2", int'(o_rght_duty), -16);
    wait_tick();
    chk("ramp_l3", int'(o_lft_duty), 20);
    chk("ramp_busy_hold", int'(o_busy), 1);
    cyc(1);
    chk("ramp_busy_drop", int'(o_busy), 0);

    // Reversal through zero with dead time.
    send(16, -16);
    wait_idle(50);
    send(-8, -16);
    wait_tick();
    chk("rev_l1", int'(o_lft_duty), 8);
    wait_tick();
    chk("rev_zero", int'(o_lft_duty), 0);
    for (int i = 0; i < DEAD_CYC; i++) begin
      cyc(1);
      chk("rev_dead_hold", int'(o_lft_duty), 0);
    end
    chk("rev_dead_busy", int'(o_busy), 1);
    wait_tick();
    chk("rev_neg", int'(o_lft_duty), -8);

    // Asynchronous reset while in dead time.
    send(8, -16);
    wait_tick();
    chk("rst_pre_zero", int'(o_lft_duty), 0);
    cyc(1);
    chk("rst_pre_busy", int'(o_busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_lft", int'(o_lft_duty), 0);
    chk("rst_async_rght", int'(o_rght_duty), 0);
    chk("rst_async_busy", int'(o_busy), 0);
    chk("rst_async_rdy", int'(o_cmd_rdy), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_tick();
    wait_tick();
    chk("rst_no_resume_l", int'(o_lft_duty), 0);
    chk("rst_no_resume_r", int'(o_rght_duty), 0);

    // Emergency stop with a command offered at the same time.
    send(100, 0);
    wait_idle(200);
    chk("estop_start", int'(o_lft_duty), 100);
    i_estop    = 1'b1;
    i_cmd_vld  = 1'b1;
    i_cmd_lft  = 12'sd500;
    #1;
    chk("estop_rdy_low", int'(o_cmd_rdy), 0);
    cyc(1);
    i_estop   = 1'b0;
    i_cmd_vld = 1'b0;
    chk("estop_lat_rdy", int'(o_cmd_rdy), 0);
    wait_tick();
    chk("estop_s1", int'(o_lft_duty), 68);
    chk("estop_not_stopped", int'(o_stopped), 0);
    wait_tick();
    chk("estop_s2", int'(o_lft_duty), 36);
    wait_tick();
    chk("estop_s3", int'(o_lft_duty), 4);
    wait_tick();
    chk("estop_s4", int'(o_lft_duty), 0);
    chk("estop_stopped", int'(o_stopped), 1);
    cyc(1);
    chk("estop_cleared", int'(o_stopped), 0);
    chk("estop_rdy_back", int'(o_cmd_rdy), 1);
    wait_tick();
    wait_tick();
    chk("estop_no_resume", int'(o_lft_duty), 0);

    // Saturation of -2048 and the positive limit.
    send(-2048, 2047);
    wait_idle(1500);
    chk("sat_lft", int'(o_lft_duty), -2047);
    chk("max_rght", int'(o_rght_duty), 2047);

    // Accept landing on a tick edge uses the old target for that tick.
    send(-2000, 2000);
    wait_tick();
    chk("edge_pre_l", int'(o_lft_duty), -2039);
    n = 0;
    while (m_cnt != TICK_CYC - 1 && n < 2 * TICK_CYC) begin
      cyc(1);
      n++;
    end
    if (m_cnt != TICK_CYC - 1) bound_fail("edge_align");
    send(-2047, 2000);
    chk("edge_old_tgt_l", int'(o_lft_duty), -2031);
    chk("edge_old_tgt_r", int'(o_rght_duty), 2031);
    wait_tick();
    chk("edge_new_tgt_l", int'(o_lft_duty), -2039);
    chk("edge_new_tgt_r", int'(o_rght_duty), 2023);
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
